// File: rtl/eth_pkg.sv
// Shared Ethernet datapath types for the transmit-side FIFO and its storage.
// The frame word carries the tlast marker alongside each byte.
package eth_pkg;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } eth_fifo_word_t;

    localparam int ETH_MIN_FRAME_LEN = 64;

    typedef enum logic {
        WR_WRITE,
        WR_DROP
    } eth_fifo_wr_state_t;

endpackage

// File: rtl/eth_fifo_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one asynchronous read port.
// The asynchronous read lets it map onto distributed RAM.
module eth_fifo_ram
    import eth_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  eth_fifo_word_t      wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output eth_fifo_word_t      rdata
);

    eth_fifo_word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_eth_tx_fifo.sv
// Store-and-forward frame FIFO feeding the GMII transmitter: only complete good frames
// become readable, so the output never stalls mid-frame while the consumer is ready.
module axis_eth_tx_fifo
    import eth_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       status_good_frame,
    output logic       status_bad_frame,
    output logic       status_overflow
);

    if (DEPTH < ETH_MIN_FRAME_LEN || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("axis_eth_tx_fifo: DEPTH must be a power of two and at least %0d", ETH_MIN_FRAME_LEN);
    end

    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PTR_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    eth_fifo_wr_state_t state, next_state;

    logic [ADDR_W:0] wr_ptr_cur, wr_ptr_commit, rd_ptr;
    logic [ADDR_W:0] next_wr_ptr_cur, next_wr_ptr_commit;
    logic            ready;
    logic            accept;
    logic            full;
    logic            empty;
    logic            we;
    logic            good_pulse, bad_pulse, ovf_pulse;
    logic            rd_load;
    eth_fifo_word_t  wr_word;
    eth_fifo_word_t  rd_word;

    assign s_axis_tready = ready;
    assign accept        = s_axis_tvalid && ready;
    assign full          = (wr_ptr_cur - rd_ptr) == PTR_DEPTH;
    assign empty         = rd_ptr == wr_ptr_commit;
    assign wr_word       = '{last: s_axis_tlast, data: s_axis_tdata};
    assign m_axis_tuser  = 1'b0;

    eth_fifo_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr_cur[ADDR_W-1:0]),
        .wdata(wr_word),
        .raddr(rd_ptr[ADDR_W-1:0]),
        .rdata(rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WR_WRITE;
            wr_ptr_cur    <= '0;
            wr_ptr_commit <= '0;
            ready         <= 1'b0;
        end else begin
            state         <= next_state;
            wr_ptr_cur    <= next_wr_ptr_cur;
            wr_ptr_commit <= next_wr_ptr_commit;
            ready         <= 1'b1;
        end
    end

    // A rejected frame rewinds the speculative pointer, so its bytes are simply overwritten later.
    always_comb begin
        next_state         = state;
        next_wr_ptr_cur    = wr_ptr_cur;
        next_wr_ptr_commit = wr_ptr_commit;
        we                 = 1'b0;
        good_pulse         = 1'b0;
        bad_pulse          = 1'b0;
        ovf_pulse          = 1'b0;
        case (state)
            WR_WRITE: begin
                if (accept) begin
                    if (full) begin
                        next_wr_ptr_cur = wr_ptr_commit;
                        ovf_pulse       = 1'b1;
                        if (!s_axis_tlast) begin
                            next_state = WR_DROP;
                        end
                    end else if (!s_axis_tlast) begin
                        we              = 1'b1;
                        next_wr_ptr_cur = wr_ptr_cur + PTR_ONE;
                    end else if (!s_axis_tuser) begin
                        we                 = 1'b1;
                        next_wr_ptr_cur    = wr_ptr_cur + PTR_ONE;
                        next_wr_ptr_commit = wr_ptr_cur + PTR_ONE;
                        good_pulse         = 1'b1;
                    end else begin
                        next_wr_ptr_cur = wr_ptr_commit;
                        bad_pulse       = 1'b1;
                    end
                end
            end
            WR_DROP: begin
                if (accept && s_axis_tlast) begin
                    next_state = WR_WRITE;
                end
            end
            default: next_state = WR_WRITE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
        end else begin
            status_good_frame <= good_pulse;
            status_bad_frame  <= bad_pulse;
            status_overflow   <= ovf_pulse;
        end
    end

    assign rd_load = (!m_axis_tvalid || m_axis_tready) && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (rd_load) begin
            rd_ptr        <= rd_ptr + PTR_ONE;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= rd_word.data;
            m_axis_tlast  <= rd_word.last;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
